// File: rtl/crcu_domain_seq.sv
// crcu_domain_seq: per-domain clock/reset sequencer.
//
// Accepts a domain configuration word over a valid/ready handshake and
// produces a divided clock-enable tick plus an ordered, active-low domain
// reset. The clock is always running before reset releases, and reset is
// always asserted before the clock stops.
//
// Optional feature: define CRCU_SEQ_RSTCNT_EN to add the rst_cnt output, a
// saturating count of soft-reset entries that clears only on master_rst.
//
// state | meaning
// ------+-----------------------------------------------------------------
// OFF   | clock gated off, domain held in reset, ready for a request
// PRE   | clock running, reset held for RST_TICKS ticks before release
// RUN   | clock running, reset released, ready for a request
// SRST  | soft reset: reset held for RST_TICKS ticks with the clock running
// POST  | disable drain: reset held, clock runs POST_TICKS ticks then stops
//
// Exit from PRE/SRST/POST happens on the edge that samples the final tick
// pulse of that state, so every tick of the state is fully visible inside
// it. For an acceptance on edge k with divide value d and N ticks the exit
// edge is k + 2 + d + (N-1)*(d+1).

module crcu_domain_seq #(
    parameter int DIV_W      = 8,
    parameter int RST_TICKS  = 4,
    parameter int POST_TICKS = 2
) (
    input  logic             master_clk,
    input  logic             master_rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_en,
    input  logic             cfg_sw_rst,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             dom_clk_en,
    output logic             dom_rst_n,
    output logic             dom_active,
    output logic [2:0]       state_o
`ifdef CRCU_SEQ_RSTCNT_EN
    ,
    output logic [15:0]      rst_cnt
`endif
);

    typedef enum logic [2:0] {
        ST_OFF  = 3'd0,
        ST_PRE  = 3'd1,
        ST_RUN  = 3'd2,
        ST_SRST = 3'd3,
        ST_POST = 3'd4
    } state_t;

    localparam int MAXT = (RST_TICKS > POST_TICKS) ? RST_TICKS : POST_TICKS;
    localparam int TCW  = $clog2(MAXT + 1);

    localparam logic [TCW-1:0] RST_LAST  = TCW'(RST_TICKS - 1);
    localparam logic [TCW-1:0] POST_LAST = TCW'(POST_TICKS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic             tick_q;
    logic [TCW-1:0]   tcnt_q;

    logic             accept;
    logic             gated;
    logic             counting;
    logic [TCW-1:0]   tick_last;
    logic             last_tick;

    // Handshake qualification and tick-count bookkeeping for the timed states
    always_comb begin
        accept    = cfg_valid & cfg_ready;
        gated     = (state_q != ST_OFF);
        counting  = (state_q == ST_PRE) || (state_q == ST_SRST) || (state_q == ST_POST);
        tick_last = (state_q == ST_POST) ? POST_LAST : RST_LAST;
        last_tick = counting && tick_q && (tcnt_q == tick_last);
    end

    // State register; master_rst forces OFF with no drain
    always_ff @(posedge master_clk) begin
        if (!master_rst) begin
            state_q <= ST_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: requests in OFF/RUN, tick-count exits from the timed states
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF: begin
                if (accept && cfg_en) begin
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                if (last_tick) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (!cfg_en) begin
                        state_d = ST_POST;
                    end else if (cfg_sw_rst) begin
                        state_d = ST_SRST;
                    end
                end
            end
            ST_SRST: begin
                if (last_tick) begin
                    state_d = ST_RUN;
                end
            end
            ST_POST: begin
                if (last_tick) begin
                    state_d = ST_OFF;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Output decode: reset released and handshake open only where allowed
    always_comb begin
        cfg_ready  = (state_q == ST_OFF) || (state_q == ST_RUN);
        dom_rst_n  = (state_q == ST_RUN);
        dom_active = (state_q == ST_RUN);
        dom_clk_en = tick_q;
        state_o    = state_q;
    end

    // Clock divider; an accepted request restarts the tick phase, and the
    // edge that enters OFF never carries a tick
    always_ff @(posedge master_clk) begin
        if (!master_rst) begin
            div_q  <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (accept) begin
            div_q  <= cfg_div;
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (!gated || (state_d == ST_OFF)) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (cnt_q == div_q) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_q + DIV_W'(1);
            tick_q <= 1'b0;
        end
    end

    // Tick counter for PRE/SRST/POST; restarts on every state change
    always_ff @(posedge master_clk) begin
        if (!master_rst) begin
            tcnt_q <= '0;
        end else if (state_d != state_q) begin
            tcnt_q <= '0;
        end else if (counting && tick_q) begin
            tcnt_q <= tcnt_q + TCW'(1);
        end
    end

`ifdef CRCU_SEQ_RSTCNT_EN
    // Saturating count of soft-reset entries
    always_ff @(posedge master_clk) begin
        if (!master_rst) begin
            rst_cnt <= '0;
        end else if ((state_q == ST_RUN) && (state_d == ST_SRST) && (rst_cnt != 16'hFFFF)) begin
            rst_cnt <= rst_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_crcu_domain_seq.sv
// Testbench for crcu_domain_seq: driver pushes one expected output word per
// clock edge into a queue from a closed-form reference model; a monitor pops
// and compares after every rising edge.
module tb_crcu_domain_seq;

    localparam int DIV_W  = 8;
    localparam int RST_T  = 4;
    localparam int POST_T = 2;

    logic             master_clk;
    logic             master_rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_en;
    logic             cfg_sw_rst;
    logic [DIV_W-1:0] cfg_div;
    logic             dom_clk_en;
    logic             dom_rst_n;
    logic             dom_active;
    logic [2:0]       state_o;
    logic [15:0]      rc_obs;
`ifdef CRCU_SEQ_RSTCNT_EN
    logic [15:0]      rst_cnt;
    assign rc_obs = rst_cnt;
`else
    assign rc_obs = 16'h0;
`endif

    crcu_domain_seq #(
        .DIV_W     (DIV_W),
        .RST_TICKS (RST_T),
        .POST_TICKS(POST_T)
    ) dut (
        .master_clk(master_clk),
        .master_rst(master_rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_en    (cfg_en),
        .cfg_sw_rst(cfg_sw_rst),
        .cfg_div   (cfg_div),
        .dom_clk_en(dom_clk_en),
        .dom_rst_n (dom_rst_n),
        .dom_active(dom_active),
        .state_o   (state_o)
`ifdef CRCU_SEQ_RSTCNT_EN
        ,
        .rst_cnt   (rst_cnt)
`endif
    );

    typedef struct packed {
        logic [2:0]  st;
        logic        tick;
        logic        rstn;
        logic        act;
        logic        rdy;
        logic [15:0] rc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   drv_timeout = 0;
    bit   to_seen = 0;

    // Reference model: domain phase, tick anchor, divide value, exit edge
    int          m_edge  = 0;
    int          m_state = 0;
    int          m_ta    = 0;
    int          m_d     = 0;
    int          m_exit  = 0;
    logic [15:0] m_rc    = 16'h0;

    initial master_clk = 1'b0;
    always #5 master_clk = ~master_clk;

    function automatic bit tick_due(input int t, input int ta, input int d);
        int k;
        k = t - ta - 1 - d;
        return (k >= 0) && ((k % (d + 1)) == 0);
    endfunction

    task automatic drive_cycle(input bit v, input bit en, input bit sw,
                               input logic [DIV_W-1:0] dv, input bit rn,
                               output bit acc);
        exp_t e;
        int   n;
        @(negedge master_clk);
        cfg_valid  = v;
        cfg_en     = en;
        cfg_sw_rst = sw;
        cfg_div    = dv;
        master_rst = rn;
        m_edge++;
        acc = 1'b0;
        if (!rn) begin
            m_state = 0;
            m_rc    = 16'h0;
        end else if (v && (m_state == 0 || m_state == 2)) begin
            acc  = 1'b1;
            m_d  = int'(dv);
            m_ta = m_edge;
            if (m_state == 0) begin
                if (en) m_state = 1;
            end else if (!en) begin
                m_state = 4;
            end else if (sw) begin
                m_state = 3;
                if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
            end
            n = (m_state == 4) ? POST_T : RST_T;
            m_exit = m_edge + 2 + m_d + (n - 1) * (m_d + 1);
        end else if ((m_state == 1 || m_state == 3 || m_state == 4) && m_edge == m_exit) begin
            m_state = (m_state == 4) ? 0 : 2;
        end
        e.st   = 3'(m_state);
        e.tick = rn && !acc && (m_state != 0) && tick_due(m_edge, m_ta, m_d);
        e.rstn = (m_state == 2);
        e.act  = (m_state == 2);
        e.rdy  = (m_state == 0) || (m_state == 2);
`ifdef CRCU_SEQ_RSTCNT_EN
        e.rc   = m_rc;
`else
        e.rc   = 16'h0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, acc);
    endtask

    task automatic rst_cycles(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, acc);
    endtask

    task automatic req(input bit en, input bit sw, input logic [DIV_W-1:0] dv);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 4000 && !acc; i++) drive_cycle(1'b1, en, sw, dv, 1'b1, acc);
        if (!acc) drv_timeout = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the queued expectation each edge
    exp_t got;
    exp_t want;
    always @(posedge master_clk) begin
        #1;
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            got  = {state_o, dom_clk_en, dom_rst_n, dom_active, cfg_ready, rc_obs};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL out_chk n=%0d got st=%0d ck=%0b rn=%0b act=%0b rdy=%0b rc=%0d want st=%0d ck=%0b rn=%0b act=%0b rdy=%0b rc=%0d",
                         total, got.st, got.tick, got.rstn, got.act, got.rdy, got.rc,
                         want.st, want.tick, want.rstn, want.act, want.rdy, want.rc);
            end
        end
        if (drv_timeout && !to_seen) begin
            to_seen = 1'b1;
            total++;
            bad++;
            $display("FAIL req_timeout got not_accepted want accepted");
        end
    end

    initial begin
        bit          acc;
        bit          pend;
        bit          p_en;
        bit          p_sw;
        bit          rn;
        logic [DIV_W-1:0] p_div;

        master_rst = 1'b0;
        cfg_valid  = 1'b0;
        cfg_en     = 1'b0;
        cfg_sw_rst = 1'b0;
        cfg_div    = '0;

        rst_cycles(3);
        idle(2);

        req(1'b1, 1'b0, 8'd0);          // power-up, divide 0
        idle(8);
        req(1'b1, 1'b1, 8'd0);          // soft reset
        idle(8);
        req(1'b1, 1'b0, 8'd1);          // divider update in RUN
        idle(5);
        req(1'b0, 1'b0, 8'd1);          // disable with drain
        idle(8);
        req(1'b1, 1'b0, 8'd3);          // power-up, divide 3
        idle(22);
        req(1'b0, 1'b0, 8'd0);          // disable, divide 0
        idle(6);
        req(1'b0, 1'b0, 8'd5);          // OFF request without enable
        idle(4);
        req(1'b1, 1'b0, 8'd1);          // abort during PRE after 2nd tick
        idle(4);
        rst_cycles(1);
        idle(3);
        req(1'b1, 1'b0, 8'd0);          // full PRE restart
        idle(8);

        pend  = 1'b0;
        p_en  = 1'b0;
        p_sw  = 1'b0;
        p_div = '0;
        for (int c = 0; c < 5000; c++) begin
            if (!pend && $urandom_range(0, 5) == 0) begin
                pend  = 1'b1;
                p_en  = ($urandom_range(0, 2) != 0);
                p_sw  = 1'($urandom_range(0, 1));
                p_div = DIV_W'($urandom_range(0, 6));
            end
            rn = ($urandom_range(0, 299) != 0);
            drive_cycle(pend, p_en, p_sw, p_div, rn, acc);
            if (acc) pend = 1'b0;
        end

        idle(3);
        @(posedge master_clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
